// File: rtl/screen_pkg.sv
// Shared screen memory map and data widths, used by the scanout, data memory and CPU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package screen_pkg;
    localparam int ADR_W          = 15;
    localparam int DATA_W         = 16;
    localparam int SCREEN_BASE    = 16384;
    localparam int SCREEN_WORDS   = 8192;
    localparam int WORDS_PER_LINE = 32;
    localparam int KBD_ADDR       = 24576;

    // Default raster geometry: 512x256 visible, 672 clks per line, 301 lines per frame.
    localparam int DEF_H_ACTIVE = 512;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 256;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef logic [ADR_W-1:0]  adr_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/video_timing_gen.sv
// Raster h/v counters with registered hsync/vsync (active low), pix_active and frame_start.
// Latency: outputs are registered from the next counter state, so they line up with h_o/v_o.
// Backpressure: none; free-running, one pixel per clk.
// Ports: clk_i/rst_i (async active-high); h_o/v_o current position; pix_active_o, hsync_o, vsync_o, frame_start_o.
module video_timing_gen
    import screen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          pix_active_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          pix_active_q, hsync_q, vsync_q, frame_start_q;
    logic          h_wrap;

    always_comb begin
        h_wrap = (h_q == HW'(H_TOTAL - 1));
        h_d    = h_wrap ? '0 : h_q + HW'(1);
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    // Reset two clocks short of the frame origin so the first visible pixel lands
    // exactly two clocks after reset release, with the line-0 prefetch in between.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q           <= HW'(H_TOTAL - 2);
            v_q           <= VW'(V_TOTAL - 1);
            pix_active_q  <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pix_active_q  <= (h_d < HW'(H_ACTIVE)) && (v_d < VW'(V_ACTIVE));
            hsync_q       <= !((h_d >= HW'(H_ACTIVE + H_FP)) &&
                               (h_d <  HW'(H_ACTIVE + H_FP + H_SYNC)));
            vsync_q       <= !((v_d >= VW'(V_ACTIVE + V_FP)) &&
                               (v_d <  VW'(V_ACTIVE + V_FP + V_SYNC)));
            frame_start_q <= (h_d == '0) && (v_d == '0);
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign pix_active_o  = pix_active_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = frame_start_q;
endmodule

// File: rtl/screen_scanout.sv
// Walks the screen region in raster order and serialises each 16-bit word into 1-bit pixels (bit 0 leftmost, 1 = black).
// Latency: word w is requested two clks before its first pixel; the read port must return data one clk after mem_rd.
// Backpressure: none; there is no stall, the memory read port must keep up every cycle.
// Ports: clk/rst (async active-high); mem_adr/mem_rd/mem_data read port; pix_out, pix_active, hsync, vsync, frame_start.
module screen_scanout
    import screen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADR_W-1:0]  mem_adr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              pix_out,
    output logic              pix_active,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WORDS   = H_ACTIVE / 16;

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (HW),       .VW   (VW)
    ) u_timing (
        .clk_i         (clk),
        .rst_i         (rst),
        .h_o           (h),
        .v_o           (v),
        .pix_active_o  (pix_active),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .frame_start_o (frame_start)
    );

    logic              line_pre, mid_line, fetch_d;
    logic [VW-1:0]     y;
    logic [ADR_W-1:0]  w, mem_adr_d, mem_adr_q;
    logic              mem_rd_q;
    logic              load;
    logic [DATA_W-1:0] word_now, shift_d, shift_q;

    // Fetch decision is taken at h = 16w-2; the strobe is visible at 16w-1 and the
    // data at 16w, the exact cycle its first pixel is shown. Word 0 of the next line
    // is prefetched at h = H_TOTAL-2 so it arrives on the line wrap.
    always_comb begin
        line_pre  = (h == HW'(H_TOTAL - 2));
        mid_line  = (h[3:0] == 4'd14) && (h < HW'(H_ACTIVE - 2));
        y         = v;
        w         = ADR_W'(h[HW-1:4]) + ADR_W'(1);
        if (line_pre) begin
            y = (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
            w = '0;
        end
        fetch_d   = (line_pre || mid_line) && (y < VW'(V_ACTIVE));
        mem_adr_d = ADR_W'(SCREEN_BASE) + ADR_W'(y) * ADR_W'(WORDS) + w;
    end

    // On a word boundary the freshly returned read data is displayed directly (the
    // memory's output register serves as the fetch buffer); its upper bits then
    // move into the shifter for the remaining 15 pixels of the word.
    always_comb begin
        load     = (h[3:0] == 4'd0) && (h < HW'(H_ACTIVE));
        word_now = load ? mem_data : shift_q;
        shift_d  = word_now >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_q  <= 1'b0;
            mem_adr_q <= ADR_W'(SCREEN_BASE);
            shift_q   <= '0;
        end else begin
            mem_rd_q  <= fetch_d;
            if (fetch_d) begin
                mem_adr_q <= mem_adr_d;
            end
            shift_q   <= shift_d;
        end
    end

    assign mem_rd  = mem_rd_q;
    assign mem_adr = mem_adr_q;
    assign pix_out = pix_active & word_now[0];
endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench: a reduced-geometry instance gets a full-frame cycle-by-cycle model check;
// a default-geometry instance is checked for release timing, line timing and line-0 fetches.
module tb_screen_scanout;
    import screen_pkg::*;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;   // 80
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;   // 15
    localparam int WPL   = HA / 16;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [14:0] mem_adr, f_mem_adr;
    logic        mem_rd, f_mem_rd;
    logic [15:0] mem_data = 16'h0, f_mem_data = 16'h0;
    logic        pix_out, pix_active, hsync, vsync, frame_start;
    logic        f_pix_out, f_pix_active, f_hsync, f_vsync, f_frame_start;

    screen_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk (clk), .rst (rst), .mem_adr (mem_adr), .mem_rd (mem_rd), .mem_data (mem_data),
        .pix_out (pix_out), .pix_active (pix_active), .hsync (hsync), .vsync (vsync),
        .frame_start (frame_start)
    );

    screen_scanout dut_full (
        .clk (clk), .rst (rst), .mem_adr (f_mem_adr), .mem_rd (f_mem_rd), .mem_data (f_mem_data),
        .pix_out (f_pix_out), .pix_active (f_pix_active), .hsync (f_hsync), .vsync (f_vsync),
        .frame_start (f_frame_start)
    );

    // Screen contents of the reduced instance: WPL words per line, VA lines.
    logic [15:0] scr [0:WPL*VA-1];
    int          bad_adr = 0;

    always @(posedge clk) begin
        if (mem_rd) begin
            if (int'(mem_adr) >= SCREEN_BASE && int'(mem_adr) < SCREEN_BASE + WPL * VA)
                mem_data <= scr[int'(mem_adr) - SCREEN_BASE];
            else begin
                mem_data <= 16'hDEAD;
                bad_adr++;
            end
        end
        if (f_mem_rd)
            f_mem_data <= (f_mem_adr == 15'd16384) ? 16'h0001 : 16'h0000;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pix_out"},     pix_out,       0);
        check({tag, "_pix_active"},  pix_active,    0);
        check({tag, "_hsync"},       hsync,         1);
        check({tag, "_vsync"},       vsync,         1);
        check({tag, "_frame_start"}, frame_start,   0);
        check({tag, "_mem_rd"},      mem_rd,        0);
        check({tag, "_mem_adr"},     mem_adr,       16384);
        check({tag, "_f_hsync"},     f_hsync,       1);
        check({tag, "_f_mem_rd"},    f_mem_rd,      0);
        check({tag, "_f_mem_adr"},   f_mem_adr,     16384);
        check({tag, "_f_active"},    f_pix_active,  0);
    endtask

    // Release reset on a falling edge and check the first two cycles of both instances.
    task automatic release_and_check(input string tag);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check({tag, "_c1_mem_rd"},   mem_rd,      1);
        check({tag, "_c1_mem_adr"},  mem_adr,     16384);
        check({tag, "_c1_fs"},       frame_start, 0);
        check({tag, "_c1_f_mem_rd"}, f_mem_rd,    1);
        check({tag, "_c1_f_adr"},    f_mem_adr,   16384);
        @(posedge clk); #1;
        check({tag, "_c2_fs"},       frame_start,   1);
        check({tag, "_c2_active"},   pix_active,    1);
        check({tag, "_c2_pix"},      pix_out,       1);
        check({tag, "_c2_f_fs"},     f_frame_start, 1);
        check({tag, "_c2_f_active"}, f_pix_active,  1);
        check({tag, "_c2_f_pix"},    f_pix_out,     1);
    endtask

    // Cycle-by-cycle model of the reduced instance over one frame; the caller has
    // just sampled the h=0, v=0 cycle.
    task automatic scan_small_frame();
        int e_pix = 0, e_act = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_rd = 0, e_adr = 0;
        int n_rd = 0, n_ones = 0;
        logic pix_first = 1'b0, pix_last = 1'b0;
        for (int t = 0; t < FRAME; t++) begin
            int h, v, y, hp, exp_adr;
            logic act, e_p, hs, vs, fs, rd;
            logic [15:0] wd;
            if (t > 0) begin
                @(posedge clk); #1;
            end
            h  = t % HT;
            v  = t / HT;
            act = (h < HA) && (v < VA);
            e_p = 1'b0;
            if (act) begin
                wd  = scr[v * WPL + h / 16];
                e_p = wd[h % 16];
            end
            hs = !((h >= HA + HF) && (h < HA + HF + HS));
            vs = !((v >= VA + VF) && (v < VA + VF + VS));
            fs = (t == 0);
            rd = 1'b0;
            exp_adr = 0;
            hp = h - 1;
            if (h > 0 && (hp % 16) == 14 && hp < HA - 2 && v < VA) begin
                rd = 1'b1;
                exp_adr = SCREEN_BASE + v * WPL + (hp + 2) / 16;
            end
            if (h == HT - 1) begin
                y = (v == VT - 1) ? 0 : v + 1;
                if (y < VA) begin
                    rd = 1'b1;
                    exp_adr = SCREEN_BASE + y * WPL;
                end
            end
            if (pix_out !== e_p)       e_pix++;
            if (pix_active !== act)    e_act++;
            if (hsync !== hs)          e_hs++;
            if (vsync !== vs)          e_vs++;
            if (frame_start !== fs)    e_fs++;
            if (mem_rd !== rd)         e_rd++;
            if (rd && int'(mem_adr) != exp_adr) e_adr++;
            if (mem_rd === 1'b1)       n_rd++;
            if (pix_out === 1'b1)      n_ones++;
            if (t == 0)                pix_first = pix_out;
            if (t == (VA - 1) * HT + HA - 1) pix_last = pix_out;
        end
        check("scan_pix_mismatches",    e_pix, 0);
        check("scan_active_mismatches", e_act, 0);
        check("scan_hsync_mismatches",  e_hs,  0);
        check("scan_vsync_mismatches",  e_vs,  0);
        check("scan_fs_mismatches",     e_fs,  0);
        check("scan_rd_mismatches",     e_rd,  0);
        check("scan_adr_mismatches",    e_adr, 0);
        check("scan_read_count",        n_rd,  32);
        check("scan_black_pixels",      n_ones, 18);
        check("scan_pix_first",         pix_first, 1);
        check("scan_pix_last",          pix_last,  1);
        check("scan_bad_adr",           bad_adr, 0);
        @(posedge clk); #1;
        check("frame_period_fs", frame_start, 1);
    endtask

    initial begin
        for (int i = 0; i < WPL * VA; i++) scr[i] = 16'h0000;
        scr[0]            = 16'h0001;   // leftmost pixel of line 0
        scr[WPL * VA - 1] = 16'h8000;   // rightmost pixel of the last visible line
        scr[2 * WPL + 1]  = 16'hA5C3;
        scr[5 * WPL + 2]  = 16'h0FF0;

        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        release_and_check("rel");

        scan_small_frame();

        // Now at h=0 of the next frame; move to v=5, h=30 and reset mid-line.
        repeat (5 * HT + 30) @(posedge clk);
        #1;
        check("pre_rst_active", pix_active, 1);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        repeat (3) begin
            @(posedge clk); #1;
            check_reset("mid_rst_hold");
        end
        release_and_check("rerel");

        // Default-geometry line timing and line-0 fetches, starting at h=0, v=0.
        begin
            int first_inact = -1, first_low = -1, rise = -1, second_low = -1;
            int f_reads = 0, f_last_adr = -1, f_ones = 0;
            for (int t = 0; t < 3000 && second_low < 0; t++) begin
                if (t > 0) begin
                    @(posedge clk); #1;
                end
                if (first_inact < 0 && f_pix_active === 1'b0) first_inact = t;
                if (first_low < 0) begin
                    if (f_hsync === 1'b0) first_low = t;
                end else if (rise < 0) begin
                    if (f_hsync === 1'b1) rise = t;
                end else if (f_hsync === 1'b0) begin
                    second_low = t;
                end
                if (t < 672) begin
                    if (f_mem_rd === 1'b1) begin
                        f_reads++;
                        f_last_adr = int'(f_mem_adr);
                    end
                    if (f_pix_out === 1'b1) f_ones++;
                end
            end
            check("full_active_width",  first_inact, 512);
            check("full_hsync_fall",    first_low, 528);
            check("full_hsync_width",   rise - first_low, 96);
            check("full_hsync_period",  second_low - first_low, 672);
            check("full_line0_reads",   f_reads, 32);
            check("full_last_adr",      f_last_adr, 16416);
            check("full_line0_ones",    f_ones, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
